// File: rtl/slv_chnl_fifo_if.sv
// Channel-side and arbiter-side handshake bundle for one slave FIFO stage.
// slv_err_o is present only when SLV_FIFO_ERR_CHK_EN is defined.
interface slv_chnl_fifo_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int MARGIN_WIDTH = 8
);
    logic                    slv_en_i;
    logic                    chnl_valid_i;
    logic [DATA_WIDTH-1:0]   chnl_data_i;
    logic                    chnl_ready_o;
    logic                    slv_val_o;
    logic [DATA_WIDTH-1:0]   slv_data_o;
    logic                    a2s_ack_i;
    logic [MARGIN_WIDTH-1:0] slv_margin_o;
`ifdef SLV_FIFO_ERR_CHK_EN
    logic                    slv_err_o;
`endif

    modport master (
        output slv_en_i, chnl_valid_i, chnl_data_i, a2s_ack_i,
        input  chnl_ready_o, slv_val_o, slv_data_o, slv_margin_o
`ifdef SLV_FIFO_ERR_CHK_EN
        , input slv_err_o
`endif
    );

    modport slave (
        input  slv_en_i, chnl_valid_i, chnl_data_i, a2s_ack_i,
        output chnl_ready_o, slv_val_o, slv_data_o, slv_margin_o
`ifdef SLV_FIFO_ERR_CHK_EN
        , output slv_err_o
`endif
    );
endinterface

// File: rtl/slv_chnl_fifo.sv
// Per-channel slave FIFO: FWFT head to the arbiter, registered free-space margin.
// Define SLV_FIFO_ERR_CHK_EN to add the sticky protocol-error flag slv_err_o.
module slv_chnl_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 32,
    parameter int MARGIN_WIDTH = 8
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    slv_chnl_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count, count_nxt;
    logic [MARGIN_WIDTH-1:0] margin;
    logic                    ready, val, push, pop, empty, full;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Ready ignores same-cycle ack: a full FIFO cannot take a word while being popped.
    assign ready = rstn_i & bus.slv_en_i & ~full;
    assign val   = bus.slv_en_i & ~empty;
    assign push  = bus.chnl_valid_i & ready;
    assign pop   = bus.a2s_ack_i & val;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            margin <= MARGIN_WIDTH'(DEPTH);
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count  <= count_nxt;
            margin <= MARGIN_WIDTH'(FULL_CNT - count_nxt);
        end
    end

    // Storage is not reset; reads are masked to zero while empty instead.
    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= bus.chnl_data_i;
    end

    assign bus.chnl_ready_o = ready;
    assign bus.slv_val_o    = val;
    assign bus.slv_data_o   = empty ? '0 : mem[rd_ptr];
    assign bus.slv_margin_o = margin;

`ifdef SLV_FIFO_ERR_CHK_EN
    logic err;

    // Ack without a head word, or a push attempt into a full enabled FIFO.
    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            err <= 1'b0;
        else if ((bus.a2s_ack_i && !val) || (bus.chnl_valid_i && bus.slv_en_i && full))
            err <= 1'b1;
    end

    assign bus.slv_err_o = err;
`endif
endmodule

// File: tb/tb_slv_chnl_fifo.sv
// Self-checking bench for slv_chnl_fifo: fixed vector table, directed sequences,
// and random traffic against a queue-based reference model.
module tb_slv_chnl_fifo;
    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] q[$];
`ifdef SLV_FIFO_ERR_CHK_EN
    logic m_err = 1'b0;
`endif

    always #5 clk = ~clk;

    slv_chnl_fifo_if #(.DATA_WIDTH(32), .MARGIN_WIDTH(8)) bus_if ();

    slv_chnl_fifo #(.DATA_WIDTH(32), .DEPTH(32), .MARGIN_WIDTH(8)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus_if)
    );

    typedef struct {
        logic        rst, en, valid;
        logic [31:0] d;
        logic        ack;
        logic        e_rdy, e_val;
        logic [31:0] e_data;
        logic [7:0]  e_mar;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic valid,
                         input logic [31:0] d, input logic ack);
        rstn                = rst;
        bus_if.slv_en_i     = en;
        bus_if.chnl_valid_i = valid;
        bus_if.chnl_data_i  = d;
        bus_if.a2s_ack_i    = ack;
    endtask

    // One clock: check outputs against the model, advance the model, then the clock edge.
    task automatic cycle(input logic rst, input logic en, input logic valid,
                         input logic [31:0] d, input logic ack);
        logic        e_rdy, e_val;
        logic [31:0] e_data;
        @(negedge clk);
        drive(rst, en, valid, d, ack);
        #1;
        e_rdy  = rst & en & (q.size() < 32);
        e_val  = en & (q.size() != 0);
        e_data = (q.size() != 0) ? q[0] : 32'h0;
        chk("ready",  {31'h0, bus_if.chnl_ready_o}, {31'h0, e_rdy});
        chk("valid",  {31'h0, bus_if.slv_val_o},    {31'h0, e_val});
        chk("data",   bus_if.slv_data_o,            e_data);
        chk("margin", {24'h0, bus_if.slv_margin_o}, 32 - q.size());
`ifdef SLV_FIFO_ERR_CHK_EN
        chk("err",    {31'h0, bus_if.slv_err_o},    {31'h0, m_err});
`endif
        if (!rst) begin
            q.delete();
`ifdef SLV_FIFO_ERR_CHK_EN
            m_err = 1'b0;
`endif
        end else begin
`ifdef SLV_FIFO_ERR_CHK_EN
            if ((ack && !e_val) || (valid && en && q.size() == 32))
                m_err = 1'b1;
`endif
            if (ack && e_val)
                void'(q.pop_front());
            if (valid && e_rdy)
                q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst  en   vld  data        ack  rdy  val  data        margin
        tbl[0] = '{1'b0, 1'b1, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b0, 32'h0,  8'h20};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 32'h0,  8'h20};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 32'hA1, 8'h1F};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hA2, 8'h1F};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 32'hAF, 1'b1, 1'b0, 1'b0, 32'hA2, 8'h1F};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA2, 8'h1F};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  8'h20};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'hB0, 1'b1, 1'b1, 1'b0, 32'h0,  8'h20};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 32'hB1, 1'b0, 1'b0, 1'b1, 32'hB0, 8'h1F};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  8'h20};

        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].en, tbl[i].valid, tbl[i].d, tbl[i].ack);
            #1;
            chk($sformatf("tbl%0d_ready", i), {31'h0, bus_if.chnl_ready_o}, {31'h0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_valid", i), {31'h0, bus_if.slv_val_o},    {31'h0, tbl[i].e_val});
            chk($sformatf("tbl%0d_data", i),  bus_if.slv_data_o,            tbl[i].e_data);
            chk($sformatf("tbl%0d_margin", i), {24'h0, bus_if.slv_margin_o}, {24'h0, tbl[i].e_mar});
            @(posedge clk);
        end

        // Reset, then fill to full with no ack; the 33rd word must be held off.
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 32; i++)
            cycle(1'b1, 1'b1, 1'b1, 32'h100 + i, 1'b0);
        chk("full_ready",  {31'h0, bus_if.chnl_ready_o}, 32'h0);
        chk("full_margin", {24'h0, bus_if.slv_margin_o}, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h120, 1'b0);
        chk("full_hold_margin", {24'h0, bus_if.slv_margin_o}, 32'h0);

        // Drain in order from full.
        for (int i = 0; i < 32; i++)
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("drain_valid",  {31'h0, bus_if.slv_val_o},    32'h0);
        chk("drain_margin", {24'h0, bus_if.slv_margin_o}, 32'h20);

        // Five resident words, then concurrent push/pop across pointer wrap.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b1, 1'b1, 32'h200 + i, 1'b0);
        for (int i = 0; i < 100; i++)
            cycle(1'b1, 1'b1, 1'b1, $urandom, 1'b1);
        chk("wrap_margin", {24'h0, bus_if.slv_margin_o}, 32'h1B);

        // Enable gating with three buffered words.
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'b0, 1'b1, 32'h300 + i, 1'b1);
        chk("gate_margin", {24'h0, bus_if.slv_margin_o}, 32'h1D);
        chk("gate_valid",  {31'h0, bus_if.slv_val_o},    32'h0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("gate_drained", {24'h0, bus_if.slv_margin_o}, 32'h20);

        // Ack on empty.
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
`ifdef SLV_FIFO_ERR_CHK_EN
        chk("err_set", {31'h0, bus_if.slv_err_o}, 32'h1);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("err_sticky", {31'h0, bus_if.slv_err_o}, 32'h1);
`else
        chk("ackempty_margin", {24'h0, bus_if.slv_margin_o}, 32'h20);
        chk("ackempty_valid",  {31'h0, bus_if.slv_val_o},    32'h0);
`endif

        // Random traffic: fill-biased phase then drain-biased phase, rare resets.
        for (int i = 0; i < 400; i++) begin
            logic r, e, v, a;
            r = ($urandom_range(0, 59) != 0);
            e = ($urandom_range(0, 9) != 0);
            if (i < 200) begin
                v = ($urandom_range(0, 9) < 8);
                a = ($urandom_range(0, 9) < 3);
            end else begin
                v = ($urandom_range(0, 9) < 3);
                a = ($urandom_range(0, 9) < 8);
            end
            cycle(r, e, v, $urandom, a);
        end

        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
